// File: rtl/cut_seq_pkg.sv
// cut_seq_pkg: shared types and helpers for the CUT test-vector sequencer.
// Holds the sequencer state enum and the MISR next-state function used when
// the design is built with SEQ_MISR_EN.
package cut_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SETTLE,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } seq_state_t;

    // Widest signature the shared MISR function supports.
    localparam int unsigned MISR_MAX_W = 64;
    localparam int unsigned MISR_IDX_W = $clog2(MISR_MAX_W);

    // One MISR step on the low 'width' bits: shift left, fold the poly in when
    // the outgoing MSB is set, then XOR the new response.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [MISR_MAX_W-1:0] data,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] shifted;
        mask    = (width >= MISR_MAX_W) ? '1
                                        : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
        shifted = (sig << 1) & mask;
        if (sig[MISR_IDX_W'(width - 1)]) begin
            shifted = shifted ^ poly;
        end
        return (shifted ^ data) & mask;
    endfunction

endpackage

// File: rtl/cut_seq_misr.sv
// cut_seq_misr: signature register compacting the emitted CUT responses.
// Only defined and instantiated when SEQ_MISR_EN is set.
`ifdef SEQ_MISR_EN
module cut_seq_misr
    import cut_seq_pkg::*;
#(
    parameter int unsigned      OUT_W     = 26,
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             update,
    input  logic [OUT_W-1:0] data,
    output logic [OUT_W-1:0] signature
);

    // Signature: cleared at run start, advanced once per accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= '0;
        end else if (clear) begin
            signature <= '0;
        end else if (update) begin
            signature <= OUT_W'(misr_next(MISR_MAX_W'(signature),
                                          MISR_MAX_W'(MISR_POLY),
                                          MISR_MAX_W'(data),
                                          OUT_W));
        end
    end

endmodule
`endif

// File: rtl/cut_test_sequencer.sv
// cut_test_sequencer: clocked apply/settle/capture engine for a combinational
// CUT. Fetches vectors from a synchronous memory, drives them onto the CUT,
// captures the response after a programmable settle time and streams it out
// over valid/ready. Define SEQ_MISR_EN to build the response signature MISR;
// without it 'signature' is tied to zero.
module cut_test_sequencer
    import cut_seq_pkg::*;
#(
    parameter int unsigned      IN_W      = 60,
    parameter int unsigned      OUT_W     = 26,
    parameter int unsigned      NUM_VEC   = 10000,
    parameter int unsigned      ADDR_W    = 14,
    parameter int unsigned      SETTLE    = 1,
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(3)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              vec_rd,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [IN_W-1:0]   vec_data,
    output logic [IN_W-1:0]   cut_in,
    input  logic [OUT_W-1:0]  cut_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic [ADDR_W-1:0] res_index,
    output logic [OUT_W-1:0]  signature
);

    localparam int unsigned       CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

    if (NUM_VEC < 1 || SETTLE < 1 ||
        64'(NUM_VEC) > (64'd1 << ADDR_W) ||
        $bits(MISR_POLY) > MISR_MAX_W) begin : g_cfg_err
        $error("cut_test_sequencer: illegal parameter combination");
    end

    seq_state_t        state;
    seq_state_t        next_state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] index_nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic              fire;

    assign busy = (state != ST_IDLE);
    assign fire = (state == ST_EMIT) && res_valid && res_ready && !abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and next-index decode; abort overrides every transition.
    always_comb begin
        next_state = state;
        index_nxt  = index;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_FETCH;
                    index_nxt  = '0;
                end
            end
            ST_FETCH:   next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: next_state = ST_EMIT;
            ST_EMIT: begin
                if (fire) begin
                    if (index == LAST_IDX) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_FETCH;
                        index_nxt  = index + ADDR_W'(1);
                    end
                end
            end
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
        if (abort) begin
            next_state = ST_IDLE;
            index_nxt  = index;
        end
    end

    // Registered outputs and datapath. Strobes are decoded from next_state
    // so they are high exactly during the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index      <= '0;
            vec_rd     <= 1'b0;
            vec_addr   <= '0;
            done       <= 1'b0;
            res_valid  <= 1'b0;
            cut_in     <= '0;
            settle_cnt <= '0;
            res_data   <= '0;
            res_index  <= '0;
        end else begin
            index     <= index_nxt;
            vec_rd    <= (next_state == ST_FETCH);
            done      <= (next_state == ST_DONE);
            res_valid <= (next_state == ST_EMIT);
            if (next_state == ST_FETCH) begin
                vec_addr <= index_nxt;
            end
            if (state == ST_LOAD && !abort) begin
                cut_in     <= vec_data;
                settle_cnt <= CNT_W'(SETTLE - 1);
            end else if (state == ST_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
            if (state == ST_CAPTURE && !abort) begin
                res_data  <= cut_out;
                res_index <= index;
            end
        end
    end

`ifdef SEQ_MISR_EN
    logic misr_clear;
    assign misr_clear = (state == ST_IDLE) && start && !abort;

    cut_seq_misr #(
        .OUT_W     (OUT_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (misr_clear),
        .update    (fire),
        .data      (res_data),
        .signature (signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_cut_test_sequencer.sv
// tb_cut_test_sequencer: self-checking bench for cut_test_sequencer.
// Two instances share stimulus: dut_a with SETTLE=1 and dut_b with SETTLE=3;
// 'sel' picks which one a run drives and observes. Honours SEQ_MISR_EN.
module tb_cut_test_sequencer;

    localparam int IN_W    = 4;
    localparam int OUT_W   = 4;
    localparam int NUM_VEC = 4;
    localparam int ADDR_W  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, res_ready;
    bit   sel;
    logic [IN_W-1:0] mem [NUM_VEC];

    int n_checks = 0;
    int n_fail   = 0;

    logic              busy_a, done_a, vec_rd_a, res_valid_a;
    logic [ADDR_W-1:0] vec_addr_a, res_index_a;
    logic [IN_W-1:0]   vec_data_a, cut_in_a;
    logic [OUT_W-1:0]  cut_out_a, res_data_a, signature_a;
    logic              busy_b, done_b, vec_rd_b, res_valid_b;
    logic [ADDR_W-1:0] vec_addr_b, res_index_b;
    logic [IN_W-1:0]   vec_data_b, cut_in_b;
    logic [OUT_W-1:0]  cut_out_b, res_data_b, signature_b;
    logic              start_a, start_b;

    assign start_a   = start & ~sel;
    assign start_b   = start & sel;
    assign cut_out_a = cut_in_a ^ 4'hA;
    assign cut_out_b = cut_in_b ^ 4'hA;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_data_a <= '0;
            vec_data_b <= '0;
        end else begin
            if (vec_rd_a) vec_data_a <= mem[vec_addr_a];
            if (vec_rd_b) vec_data_b <= mem[vec_addr_b];
        end
    end

    cut_test_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NUM_VEC), .ADDR_W(ADDR_W),
        .SETTLE(1), .MISR_POLY(4'h3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .busy(busy_a), .done(done_a), .vec_rd(vec_rd_a), .vec_addr(vec_addr_a),
        .vec_data(vec_data_a), .cut_in(cut_in_a), .cut_out(cut_out_a),
        .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
        .res_index(res_index_a), .signature(signature_a)
    );

    cut_test_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NUM_VEC), .ADDR_W(ADDR_W),
        .SETTLE(3), .MISR_POLY(4'h3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .busy(busy_b), .done(done_b), .vec_rd(vec_rd_b), .vec_addr(vec_addr_b),
        .vec_data(vec_data_b), .cut_in(cut_in_b), .cut_out(cut_out_b),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
        .res_index(res_index_b), .signature(signature_b)
    );

    logic              busy, done, vec_rd, res_valid;
    logic [ADDR_W-1:0] vec_addr, res_index;
    logic [3:0]        cut_in, res_data, signature;
    assign busy      = sel ? busy_b      : busy_a;
    assign done      = sel ? done_b      : done_a;
    assign vec_rd    = sel ? vec_rd_b    : vec_rd_a;
    assign res_valid = sel ? res_valid_b : res_valid_a;
    assign vec_addr  = sel ? vec_addr_b  : vec_addr_a;
    assign res_index = sel ? res_index_b : res_index_a;
    assign cut_in    = sel ? cut_in_b    : cut_in_a;
    assign res_data  = sel ? res_data_b  : res_data_a;
    assign signature = sel ? signature_b : signature_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference signature step, straight from the MISR definition.
    function automatic logic [3:0] misr_step(input logic [3:0] s, input logic [3:0] d);
        logic [4:0] t;
        t = {s, 1'b0};
        return t[3:0] ^ (s[3] ? 4'h3 : 4'h0) ^ d;
    endfunction

    function automatic logic [3:0] exp_sig(input logic [3:0] s);
`ifdef SEQ_MISR_EN
        return s;
`else
        return s & 4'h0;
`endif
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_vec_rd"},    vec_rd,    0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_vec_addr"},  vec_addr,  0);
        check({tag, "_cut_in"},    cut_in,    0);
        check({tag, "_res_data"},  res_data,  0);
        check({tag, "_res_index"}, res_index, 0);
        check({tag, "_signature"}, signature, 0);
    endtask

    // One run: start at edge 0, then observe cycle n at the negedge after
    // edge n-1. kill_cyc>0 aborts (or resets, kill_rst) at that cycle.
    task automatic run(input int kill_cyc, input bit kill_rst, input bit poke,
                       input bit rand_ready, input int stall1);
        int         per, acc, exp_done, k_fetch, k_emit, stalled;
        int         stall_plan [NUM_VEC];
        int         fetch_at   [NUM_VEC];
        logic [3:0] esig;
        bit         got_done;
        per = 4 + (sel ? 3 : 1);
        acc = 0;
        for (int k = 0; k < NUM_VEC; k++) begin
            stall_plan[k] = rand_ready ? int'($urandom_range(0, 3)) : ((k == 1) ? stall1 : 0);
            fetch_at[k]   = 1 + k * per + acc;
            acc          += stall_plan[k];
        end
        exp_done = 1 + NUM_VEC * per + acc;
        k_fetch = 0; k_emit = 0; stalled = 0; esig = 4'h0; got_done = 0;
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= exp_done + 20; n++) begin
            @(negedge clk);
            start = poke && (n % 3 == 0) && (n < exp_done);
            check("busy_in_run", busy, 1);
            if (vec_rd) begin
                if (k_fetch < NUM_VEC) begin
                    check("fetch_cycle", n, fetch_at[k_fetch]);
                    check("vec_addr", vec_addr, k_fetch);
                end else begin
                    check("fetch_count", k_fetch + 1, NUM_VEC);
                end
                k_fetch++;
            end
            res_ready = 1'b1;
            if (res_valid) begin
                if (k_emit < NUM_VEC) begin
                    check("res_data", res_data, mem[k_emit] ^ 4'hA);
                    check("res_index", res_index, k_emit);
                    if (stalled < stall_plan[k_emit]) begin
                        res_ready = 1'b0;
                        stalled++;
                    end else begin
                        esig = misr_step(esig, mem[k_emit] ^ 4'hA);
                        k_emit++;
                        stalled = 0;
                    end
                end else begin
                    check("result_count", k_emit + 1, NUM_VEC);
                end
            end
            if (n == kill_cyc) begin
                if (kill_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check_zero("reset_mid");
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                end else begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_busy", busy, 0);
                    check("abort_valid", res_valid, 0);
                    check("abort_sig", signature, exp_sig(esig));
                    for (int j = 0; j < 6; j++) begin
                        @(negedge clk);
                        check("abort_no_done", done, 0);
                    end
                end
                res_ready = 1'b1;
                return;
            end
            if (done) begin
                check("done_cycle", n, exp_done);
                check("fetches", k_fetch, NUM_VEC);
                check("results", k_emit, NUM_VEC);
                check("cut_in_hold", cut_in, mem[NUM_VEC-1]);
                check("signature", signature, exp_sig(esig));
                got_done = 1;
                break;
            end
        end
        check("done_seen", got_done, 1);
        start = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1; sel = 1'b0;
        for (int k = 0; k < NUM_VEC; k++) mem[k] = 4'(k);
        repeat (2) @(negedge clk);
        check_zero("reset_a");
        sel = 1'b1;
        check_zero("reset_b");
        sel = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 0, 0, 0, 0);          // basic run, done in cycle 21
        run(0, 0, 0, 0, 3);          // 3 stall cycles on vector 1, done in 24
        run(13, 0, 0, 0, 0);         // abort in SETTLE of vector 2
        run(0, 0, 0, 0, 0);          // restart replays from index 0
        run(0, 0, 1, 0, 0);          // start pokes while busy are ignored
        sel = 1'b1;
        run(0, 0, 0, 0, 0);          // SETTLE=3, done in cycle 29
        sel = 1'b0;
        run(10, 1, 0, 0, 0);         // reset during EMIT of vector 1
        run(0, 0, 0, 0, 0);          // fresh run after reset

        for (int r = 0; r < 8; r++) begin
            sel = 1'($urandom_range(0, 1));
            for (int k = 0; k < NUM_VEC; k++) mem[k] = 4'($urandom_range(0, 15));
            run(0, 0, 0, 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
